// File: rtl/enc_pkg.sv
// enc_pkg: shared types and defaults for the base_encoder slice.
//   ENC_OUT_W / ENC_CNT_W : default index and error-counter widths
//   occ_e                 : output-buffer occupancy state
//   enc_res_t             : one encoded result {out, out_en, out_err}
// The result struct is sized by ENC_OUT_W, so instances must keep OUT_W at
// that value (CNT_W is free to change).
package enc_pkg;

  localparam int ENC_OUT_W = 2;
  localparam int ENC_CNT_W = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [ENC_OUT_W-1:0] out;
    logic                 out_en;
    logic                 out_err;
  } enc_res_t;

endpackage

// File: rtl/prio_enc_comb.sv
// prio_enc_comb: combinational priority encoder.
//   in  : one-hot (ideally) input word, 2**OUT_W bits
//   en  : encode enable; when low the result is all zero
//   res : {index of highest set bit, index valid, multi-hot flag}
// Build option BASE_ENCODER_ERRCHK_EN: when undefined the multi-hot detector
// is not built and res.out_err is constant 0.
module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int OUT_W = ENC_OUT_W
) (
  input  logic [2**OUT_W-1:0] in,
  input  logic                en,
  output enc_res_t            res
);

  always_comb begin
`ifdef BASE_ENCODER_ERRCHK_EN
    logic seen;
    seen = 1'b0;
`endif
    res = '0;
    if (en) begin
      // Ascending scan: the last hit is the highest set bit.
      for (int i = 0; i < 2**OUT_W; i++) begin
        if (in[i]) begin
          res.out    = OUT_W'(i);
          res.out_en = 1'b1;
`ifdef BASE_ENCODER_ERRCHK_EN
          if (seen) res.out_err = 1'b1;
          seen = 1'b1;
`endif
        end
      end
    end
  end

endmodule

// File: rtl/base_encoder.sv
// base_encoder: registered priority encoder with a 2-entry output buffer.
//   clk, rst            : clock, async active-high reset
//   in_valid/in_ready   : input handshake (in_ready registered)
//   in, en              : input word and encode enable
//   out_valid/out_ready : output handshake
//   out, out_en, out_err: head-of-buffer result
//   err_cnt             : saturating count of accepted multi-hot words
// Build option BASE_ENCODER_ERRCHK_EN: enables multi-hot flagging and err_cnt;
// when undefined out_err and err_cnt are 0.
module base_encoder
  import enc_pkg::*;
#(
  parameter int OUT_W = ENC_OUT_W,
  parameter int CNT_W = ENC_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2**OUT_W-1:0] in,
  input  logic                en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out,
  output logic                out_en,
  output logic                out_err,
  output logic [CNT_W-1:0]    err_cnt
);

  occ_e     state_q, state_d;
  enc_res_t head_q, head_d;
  enc_res_t skid_q, skid_d;
  logic     in_ready_q, in_ready_d;
  enc_res_t enc_res;
  logic     acc, drn;

  prio_enc_comb #(.OUT_W(OUT_W)) u_prio (
    .in  (in),
    .en  (en),
    .res (enc_res)
  );

  assign acc = in_valid & in_ready_q;
  assign drn = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= OCC_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OCC_EMPTY: if (acc) state_d = OCC_ONE;
      OCC_ONE: begin
        if (acc && !drn)      state_d = OCC_TWO;
        else if (!acc && drn) state_d = OCC_EMPTY;
      end
      OCC_TWO:   if (drn) state_d = OCC_ONE;
      default:   state_d = OCC_EMPTY;
    endcase
  end

  // Outputs and buffer data
  always_comb begin
    out_valid  = (state_q != OCC_EMPTY);
    in_ready_d = (state_d != OCC_TWO);
    head_d     = head_q;
    skid_d     = skid_q;
    unique case (state_q)
      OCC_EMPTY: if (acc) head_d = enc_res;
      OCC_ONE: begin
        // Accept together with drain overwrites the head: no bubble.
        if (acc && drn) head_d = enc_res;
        else if (acc)   skid_d = enc_res;
      end
      OCC_TWO:   if (drn) head_d = skid_q;
      default:   ;
    endcase
  end

  assign in_ready = in_ready_q;
  assign out      = head_q.out;
  assign out_en   = head_q.out_en;
  assign out_err  = head_q.out_err;

`ifdef BASE_ENCODER_ERRCHK_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counted at acceptance, saturating at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (acc && enc_res.out_err && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_base_encoder.sv
module tb_base_encoder;
  import enc_pkg::*;

`ifdef BASE_ENCODER_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, en;
  logic [3:0] in;
  logic       in_ready, out_valid, out_en, out_err;
  logic       in_ready_s, out_valid_s, out_en_s, out_err_s;
  logic [1:0] out, out_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;

  always #5 clk = ~clk;

  base_encoder #(.OUT_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in(in), .en(en), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_en(out_en), .out_err(out_err), .err_cnt(err_cnt)
  );

  // Narrow-counter instance sharing all inputs; its handshake matches dut.
  base_encoder #(.OUT_W(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in(in), .en(en), .out_valid(out_valid_s), .out_ready(out_ready),
    .out(out_s), .out_en(out_en_s), .out_err(out_err_s), .err_cnt(err_cnt_s)
  );

  typedef struct {
    logic [3:0] w;
    logic       e;
    logic [1:0] o;
    logic       oe;
    logic       oerr;
  } exp_t;

  typedef struct {
    logic [3:0] w;
    logic       e;
  } src_t;

  exp_t sb[$];
  src_t src[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;
  bit   exp_rdy = 1'b0;
  int   exp_cnt = 0;
  int   exp_cnt_s = 0;
  bit   last_acc;
  bit   rt_mode = 1'b0;
  int   cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] w, input logic e);
    exp_t r;
    r.w = w; r.e = e; r.o = 2'd0; r.oe = 1'b0; r.oerr = 1'b0;
    if (e && (w != 4'b0000)) begin
      r.oe = 1'b1;
      for (int k = 3; k >= 0; k--) begin
        if (w[k]) begin
          r.o = 2'(k);
          break;
        end
      end
      r.oerr = ERRCHK && ($countones(w) > 1);
    end
    return r;
  endfunction

  // One clock: check the current state, update the model, cross the edge.
  task automatic tick();
    bit   acc, drn;
    exp_t h;
    logic [3:0] dec;
    chk("in_ready", in_ready, exp_rdy);
    chk("in_ready_sat", in_ready_s, exp_rdy);
    chk("out_valid", out_valid, sb.size() != 0);
    chk("err_cnt", err_cnt, exp_cnt);
    chk("err_cnt_sat", err_cnt_s, exp_cnt_s);
    acc = in_valid && exp_rdy;
    drn = (sb.size() != 0) && out_ready;
    if (sb.size() != 0) begin
      h = sb[0];
      chk("out", out, h.o);
      chk("out_en", out_en, h.oe);
      chk("out_err", out_err, h.oerr);
      if (drn) begin
        if (rt_mode) begin
          dec = out_en ? (4'b0001 << out) : 4'b0000;
          chk("roundtrip", dec, h.e ? h.w : 4'b0000);
        end
        void'(sb.pop_front());
      end
    end
    if (acc) begin
      h = model(in, en);
      sb.push_back(h);
      if (h.oerr) begin
        if (exp_cnt < 255) exp_cnt++;
        if (exp_cnt_s < 3) exp_cnt_s++;
      end
    end
    last_acc = acc;
    exp_rdy = (sb.size() < 2);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive();
    if (src.size() != 0) begin
      in_valid = 1'b1; in = src[0].w; en = src[0].e;
    end else begin
      in_valid = 1'b0; in = 4'($urandom_range(15)); en = 1'($urandom_range(1));
    end
  endtask

  task automatic pump(input int max_cycles, output int cycles);
    cycles = 0;
    while (((src.size() != 0) || (sb.size() != 0)) && (cycles < max_cycles)) begin
      drive();
      tick();
      if (last_acc) void'(src.pop_front());
      cycles++;
    end
    in_valid = 1'b0;
    chk("pump_drained", src.size() + sb.size(), 0);
  endtask

  task automatic add(input logic [3:0] w, input logic e);
    src_t s;
    s.w = w; s.e = e;
    src.push_back(s);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in = 4'b0; en = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out", out, 0);
    chk("rst_out_en", out_en, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single words
    add(4'b1000, 1'b1); pump(10, cyc);
    add(4'b0010, 1'b1); pump(10, cyc);
    add(4'b1000, 1'b0); pump(10, cyc);

    // Malformed words
    add(4'b0110, 1'b1); pump(10, cyc);
    chk("malformed_cnt", err_cnt, ERRCHK ? 1 : 0);
    add(4'b0000, 1'b1); pump(10, cyc);
    chk("zero_cnt_hold", err_cnt, ERRCHK ? 1 : 0);

    // Backpressure: only two words fit
    out_ready = 1'b0;
    add(4'b0001, 1'b1); add(4'b0100, 1'b1); add(4'b0010, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(); tick();
      if (last_acc) void'(src.pop_front());
    end
    chk("bp_pending", src.size(), 1);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out, 2'd0);
    out_ready = 1'b1;
    pump(20, cyc);

    // Streaming: 16 words in 17 clocks means no bubbles
    for (int i = 0; i < 16; i++) add(4'b0001 << (i % 4), 1'b1);
    pump(40, cyc);
    chk("stream_cycles", cyc, 17);

    // Round trip through a decoder model
    rt_mode = 1'b1;
    for (int i = 0; i < 4; i++) add(4'b0001 << i, 1'b1);
    add(4'b1000, 1'b0);
    add(4'b0100, 1'b0);
    pump(20, cyc);
    rt_mode = 1'b0;

    // Reset while TWO, with nonzero error count
    out_ready = 1'b0;
    add(4'b0011, 1'b1); add(4'b0101, 1'b1); add(4'b0001, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(); tick();
      if (last_acc) void'(src.pop_front());
    end
    chk("pre_rst_full", in_ready, 0);
    chk("pre_rst_cnt", err_cnt, ERRCHK ? 3 : 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_err_cnt_sat", err_cnt_s, 0);
    #1 rst = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    sb.delete(); src.delete();
    exp_rdy = 1'b0; exp_cnt = 0; exp_cnt_s = 0;
    tick();
    tick();
    tick();

    // Saturation on the 2-bit counter: 1,2,3,3,3
    add(4'b1100, 1'b1); add(4'b0011, 1'b1); add(4'b1111, 1'b1);
    add(4'b1010, 1'b1); add(4'b0110, 1'b1);
    pump(20, cyc);
    chk("sat_final", err_cnt_s, ERRCHK ? 3 : 0);
    chk("wide_final", err_cnt, ERRCHK ? 5 : 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
